// File: rtl/pe_inject_arbiter.sv
// pe_inject_arbiter: round-robin share of one ring node's PE injection port among local requesters
module pe_inject_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 64,
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_en,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  pesi,
    output logic [DW-1:0]         pedi,
    input  logic                  peri,
    output logic [2:0]            grant_id,
    output logic [15:0]           inj_count,
    output logic                  stall_err
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t                 state, state_next;
    logic [2:0]             ptr, sel;
    logic [3:0]             sum;
    logic [NUM_REQ-1:0]     elig, onehot;
    logic [2*NUM_REQ-1:0]   rot;
    logic                   found, load_ok, load, accept;
    logic [DW-1:0]          sel_data;
    logic [TO_W-1:0]        stall_cnt, stall_next;
    // rotate the eligible set by ptr and take the first set bit; data is an AND-OR mux on the one-hot grant
    always_comb begin
        elig = req_valid & req_en;
        rot = {elig, elig} >> ptr;
        found = 1'b0;
        sel = 3'd0;
        sum = 4'd0;
        onehot = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum = 4'(ptr) + 4'(k);
                sel = 3'(sum >= 4'(NUM_REQ) ? sum - 4'(NUM_REQ) : sum);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            onehot[i] = found && (sel == 3'(i));
            sel_data = sel_data | (req_data[i*DW +: DW] & {DW{onehot[i]}});
        end
    end
    // load/accept decisions, next state and the combinational grant
    always_comb begin
        load_ok = (state == EMPTY) || (state == FULL && peri);
        load = load_ok && found;
        accept = (state == FULL) && peri;
        state_next = load ? FULL : accept ? EMPTY : state;
        req_ready = load_ok ? onehot : '0;
        stall_next = accept ? '0 : (state == FULL && stall_cnt != TO_W'(TIMEOUT)) ? stall_cnt + 1'b1 : stall_cnt;
    end
    assign pesi = (state == FULL);
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else state <= state_next;
    end
    // output register, round-robin pointer, accept counter and stall watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            pedi <= '0;
            grant_id <= 3'd0;
            ptr <= 3'd0;
            inj_count <= 16'd0;
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            if (load) begin
                pedi <= sel_data;
                grant_id <= sel;
                ptr <= (sel == 3'(NUM_REQ-1)) ? 3'd0 : sel + 3'd1;
            end
            if (accept) inj_count <= inj_count + 16'd1;
            stall_cnt <= stall_next;
            if (stall_next == TO_W'(TIMEOUT)) stall_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pe_inject_arbiter.sv
// tb_pe_inject_arbiter: directed checks of grant order, hold, stall flag, reset and counter wrap
module tb_pe_inject_arbiter;
    localparam int N = 4;
    localparam int DW = 64;
    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_en, req_valid, req_ready;
    logic [N*DW-1:0] req_data;
    logic            pesi, peri, stall_err;
    logic [DW-1:0]   pedi;
    logic [2:0]      grant_id;
    logic [15:0]     inj_count;
    int              checks = 0;
    int              failures = 0;

    pe_inject_arbiter #(.NUM_REQ(N), .DW(DW), .TIMEOUT(200), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .req_en(req_en), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .pesi(pesi), .pedi(pedi),
        .peri(peri), .grant_id(grant_id), .inj_count(inj_count), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pkt(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    initial begin
        int seq_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int seq_b [6] = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pkt(i);
        reset = 1'b1; req_en = 4'hF; req_valid = 4'h0; peri = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("idle_pesi", 64'(pesi), 0);
        check("idle_ready", 64'(req_ready), 0);
        check("idle_count", 64'(inj_count), 0);
        check("idle_err", 64'(stall_err), 0);
        // single request from requester 2
        req_valid = 4'b0100;
        #1 check("single_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0000;
        check("single_pesi", 64'(pesi), 1);
        check("single_pedi", pedi, 64'hA5A5_0000_0000_0002);
        check("single_gid", 64'(grant_id), 2);
        tick();
        check("single_count", 64'(inj_count), 1);
        check("single_empty", 64'(pesi), 0);
        // round robin with all valid from ptr 0
        reset = 1'b1; tick(); reset = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rr_gid%0d", k), 64'(grant_id), 64'(seq_a[k]));
            check($sformatf("rr_pedi%0d", k), pedi, pkt(seq_a[k]));
            check($sformatf("rr_pesi%0d", k), 64'(pesi), 1);
        end
        req_valid = 4'h0;
        tick();
        check("rr_count", 64'(inj_count), 8);
        check("rr_empty", 64'(pesi), 0);
        // hold requester 1 while the router blocks
        req_valid = 4'b0010; peri = 1'b0;
        tick();
        check("hold_gid", 64'(grant_id), 1);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1 check($sformatf("hold_ready%0d", k), 64'(req_ready), 0);
            tick();
            check($sformatf("hold_pedi%0d", k), pedi, pkt(1));
            check($sformatf("hold_gid%0d", k), 64'(grant_id), 1);
        end
        peri = 1'b1;
        #1 check("resume_ready", 64'(req_ready), 64'b0100);
        tick();
        check("resume_gid", 64'(grant_id), 2);
        check("resume_pesi", 64'(pesi), 1);
        check("resume_count", 64'(inj_count), 9);
        req_valid = 4'h0;
        tick();
        check("resume_count2", 64'(inj_count), 10);
        // stall watchdog
        req_valid = 4'b0001; peri = 1'b0;
        tick();
        req_valid = 4'h0;
        check("stall_gid", 64'(grant_id), 0);
        for (int k = 0; k < 199; k++) tick();
        check("stall_199", 64'(stall_err), 0);
        tick();
        check("stall_200", 64'(stall_err), 1);
        peri = 1'b1;
        tick();
        check("stall_accept", 64'(inj_count), 11);
        check("stall_pesi", 64'(pesi), 0);
        check("stall_sticky", 64'(stall_err), 1);
        tick();
        check("stall_sticky2", 64'(stall_err), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("stall_reset", 64'(stall_err), 0);
        // requester 2 masked
        req_en = 4'b1011; req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1 check($sformatf("mask_ready%0d", k), 64'(req_ready[2]), 0);
            tick();
            check($sformatf("mask_gid%0d", k), 64'(grant_id), 64'(seq_b[k]));
        end
        check("mask_count", 64'(inj_count), 5);
        check("mask_pesi", 64'(pesi), 1);
        // reset while full
        req_en = 4'hF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_pesi", 64'(pesi), 0);
        check("rst_count", 64'(inj_count), 0);
        check("rst_gid", 64'(grant_id), 0);
        check("rst_pedi", pedi, 0);
        #1 check("rst_ready", 64'(req_ready), 64'b0001);
        tick();
        check("rst_grant", 64'(grant_id), 0);
        // counter wrap with continuous traffic
        for (int k = 0; k < 65535; k++) tick();
        check("wrap_ffff", 64'(inj_count), 64'hFFFF);
        tick();
        check("wrap_zero", 64'(inj_count), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
